// File: rtl/ins_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response, decoder handshake and redirect.
// master = fetch stage, slave = memory/decoder/backend side.
interface ins_fetch_if;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        ins_valid;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        ins_pred_taken;
   logic        ins_ready;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output ins_valid, ins, ins_pc, ins_pred_taken,
      input  ins_ready, flush, flush_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  ins_valid, ins, ins_pc, ins_pred_taken,
      output ins_ready, flush, flush_pc
   );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: one outstanding word request, in-order instruction queue, flush redirect.
// Optional JAL next-PC prediction when FETCH_JAL_PREDICT_EN is defined.
module ins_fetch #(
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   ins_fetch_if.master bus
);
   localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
   localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(QUEUE_DEPTH);
   localparam logic [PtrW:0]   CountOne  = (PtrW + 1)'(1);
   localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

   typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q;
   logic [PtrW-1:0]   head_q, tail_q;
   logic [PtrW:0]     count_q;
   logic [31:0]       q_ins  [QUEUE_DEPTH];
   logic [31:0]       q_pc   [QUEUE_DEPTH];
   logic              q_pred [QUEUE_DEPTH];

   logic        req_fire, push, pop, next_pred;
   logic [31:0] next_pc;

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an in-flight response is always consumed before returning to idle.
   always_comb begin
      state_d = state_q;
      if (rdy_in) begin
         case (state_q)
            StIdle: if (req_fire) state_d = StWait;
            StWait: begin
               if (bus.mem_resp_valid) state_d = StIdle;
               else if (bus.flush)     state_d = StDrop;
            end
            StDrop: if (bus.mem_resp_valid) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs and handshake qualifiers
   always_comb begin
      bus.mem_req_valid  = rst_in & rdy_in & (state_q == StIdle) & ~bus.flush &
                           (count_q < CountFull);
      bus.mem_req_addr   = pc_q;
      bus.ins_valid      = rst_in & rdy_in & (count_q != '0);
      bus.ins            = q_ins[head_q];
      bus.ins_pc         = q_pc[head_q];
      bus.ins_pred_taken = q_pred[head_q];
      req_fire           = bus.mem_req_valid & bus.mem_req_ready;
      push               = rdy_in & ~bus.flush & (state_q == StWait) & bus.mem_resp_valid;
      pop                = bus.ins_valid & bus.ins_ready & ~bus.flush;
   end

   // Next fetch PC after a returned word
`ifdef FETCH_JAL_PREDICT_EN
   logic [31:0] jal_imm;
   always_comb begin
      jal_imm   = {{11{bus.mem_resp_data[31]}}, bus.mem_resp_data[31],
                   bus.mem_resp_data[19:12], bus.mem_resp_data[20],
                   bus.mem_resp_data[30:21], 1'b0};
      next_pred = (bus.mem_resp_data[6:0] == 7'b1101111);
      next_pc   = next_pred ? pc_q + jal_imm : pc_q + 32'd4;
   end
`else
   always_comb begin
      next_pred = 1'b0;
      next_pc   = pc_q + 32'd4;
   end
`endif

   // Fetch PC and instruction queue
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_ins[i]  <= '0;
            q_pc[i]   <= '0;
            q_pred[i] <= 1'b0;
         end
      end else if (rdy_in) begin
         if (bus.flush) begin
            pc_q    <= bus.flush_pc;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               q_ins[tail_q]  <= bus.mem_resp_data;
               q_pc[tail_q]   <= pc_q;
               q_pred[tail_q] <= next_pred;
               tail_q         <= tail_q + PtrOne;
               pc_q           <= next_pc;
            end
            if (pop) head_q <= head_q + PtrOne;
            if (push && !pop)      count_q <= count_q + CountOne;
            else if (pop && !push) count_q <= count_q - CountOne;
         end
      end
   end
endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the fetch PC and issues one-at-a-time word requests to the instruction memory/cache port.
- Buffers returned instruction words with their PCs in a small in-order queue and presents the head entry to the decoder with a valid/ready handshake.
- Accepts redirect (flush) commands from the backend.

Parameters:
- QUEUE_DEPTH, 4, instruction queue entries; power of two, minimum 2.
- RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global enable; low freezes the block.
- mem_req_valid  output  1  fetch request valid.
- mem_req_addr  output  32  fetch byte address; always equals the fetch PC.
- mem_req_ready  input  1  memory accepts the request this cycle.
- mem_resp_valid  input  1  instruction word returned this cycle.
- mem_resp_data  input  32  returned instruction word.
- ins_valid  output  1  queue head valid, toward the decoder.
- ins  output  32  head instruction word; feeds the decoder ins input.
- ins_pc  output  32  PC of the head instruction.
- ins_pred_taken  output  1  fetch redirected after this instruction (JAL prediction).
- ins_ready  input  1  downstream consumes the head this cycle.
- flush  input  1  redirect request; discard all fetched and in-flight work.
- flush_pc  input  32  new fetch PC when flush=1.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - fetch PC = RESET_PC; state = IDLE; queue empty.
  - mem_req_valid=0, ins_valid=0, ins=0, ins_pc=0, ins_pred_taken=0.
- State machine: IDLE, WAIT, DROP.
- Request issue:
  - mem_req_valid = (state==IDLE) & rdy_in & !flush & (count < QUEUE_DEPTH). It is combinational.
  - mem_req_addr = fetch PC.
  - The request is accepted when mem_req_valid & mem_req_ready; state goes IDLE->WAIT.
  - The queue slot is effectively reserved by the single outstanding request, so a push never meets a full queue.
- Response in WAIT, on mem_resp_valid:
  - Push {mem_resp_data, fetch PC, pred} at the tail.
  - fetch PC <= next PC.
  - State goes to IDLE.
- Next PC is fetch PC + 4 (32-bit wrap-around, no overflow detection), unless the optional feature redirects.
- Earliest next request is the cycle after the response, so throughput is at most 1 instruction per 2 cycles plus memory latency.
- Queue:
  - Circular buffer with head/tail pointers of log2(QUEUE_DEPTH) bits, wrapping naturally, plus a count of log2(QUEUE_DEPTH)+1 bits.
  - ins_valid = (count != 0) & rdy_in. ins, ins_pc and ins_pred_taken come from the head entry.
  - Pop on ins_valid & ins_ready.
  - Push and pop in the same cycle keep count unchanged; this is legal even at count == QUEUE_DEPTH-1 or when full-with-pop.
- Latency: a response in cycle t makes the instruction visible on ins_valid in cycle t+1.
- Flush has priority over push, pop and request in the same cycle:
  - Queue cleared (count=0, head=tail=0); fetch PC <= flush_pc.
  - From IDLE: stay in IDLE. No request is issued in the flush cycle; the first request is at flush_pc in the next cycle.
  - From WAIT with mem_resp_valid in the same cycle: the response is discarded; go to IDLE.
  - From WAIT without a response: go to DROP.
  - DROP: mem_req_valid=0; the first mem_resp_valid is discarded and the state goes to IDLE.
  - A flush while in DROP updates fetch PC and stays in DROP.
- rdy_in=0:
  - No register updates, except asynchronous reset.
  - mem_req_valid=0, ins_valid=0.
  - The memory side guarantees no mem_resp_valid while rdy_in=0.
- A mem_resp_valid while IDLE is a protocol error and is ignored.

Optional Feature:
- Macro name: FETCH_JAL_PREDICT_EN.
- Defined:
  - On a response whose bits [6:0] == 7'b1101111 (JAL), next PC = fetch PC + sign-extended J-immediate, i.e. {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} sign-extended to 32 bits.
  - The entry is stored with pred_taken=1.
- Not defined:
  - Next PC is always fetch PC + 4 and ins_pred_taken is constant 0.
  - JAL is resolved downstream via flush.
- Conditional branches and JALR are never predicted in either configuration.

Test Plan:
- Reset then memory with 1-cycle ready and 1-cycle response, ins_ready=1 -> requests at 0x0, 0x4, 0x8 in order; ins_pc sequence 0x0, 0x4, 0x8 with matching words; each ins_valid one cycle after its response.
- ins_ready=0 with QUEUE_DEPTH=4 -> exactly 4 entries fetched, then mem_req_valid stays 0; one pop then re-enables exactly one request at 0x10.
- Flush to 0x100 while in WAIT, response arriving 3 cycles later -> that word is dropped, ins_valid stays 0; next request addr is 0x100 and the first delivered ins_pc is 0x100.
- Flush coinciding with mem_resp_valid and a pop -> queue empty next cycle, response discarded, state IDLE, next request at flush_pc.
- With FETCH_JAL_PREDICT_EN, word 0x0100006F (jal x0,+16) at 0x20 -> ins_pred_taken=1 and the next request addr is 0x30. Without the macro the next addr is 0x24 and pred_taken=0.
- rdy_in held low 5 cycles mid-stream, then reset asserted asynchronously with a request pending -> outputs frozen and no handshakes during the pause; after reset, all outputs are 0 and the next request addr is RESET_PC.
